// File: rtl/rate_tick_pkg.sv
// rate_tick_pkg: shared FSM state type, divider helper and reset constants for rate_tick_gen
package rate_tick_pkg;

    typedef enum logic [1:0] {
        RUN_SLOW = 2'd0,
        ARM_FAST = 2'd1,
        RUN_FAST = 2'd2,
        ARM_SLOW = 2'd3
    } rate_state_t;

    localparam logic SD_DB_RST    = 1'b1;
    localparam logic SEL_SLOW_RST = 1'b1;

    function automatic int div_of(input int clk_hz, input int hz);
        return clk_hz / hz;
    endfunction

endpackage

// File: rtl/sd_debounce.sv
// sd_debounce: 2-FF synchronizer plus debouncer for the raw speed switch
// Ports: clk (rising edge), rst_n (sync, active low), d_in (raw async switch), d_out (clean level, resets to 1)
// Macro RATE_TICK_DEBOUNCE_EN: defined -> d_out changes only after DB_CYC stable cycles;
//                              undefined -> d_out follows the synchronized input one cycle later.
module sd_debounce
    import rate_tick_pkg::*;
#(
    parameter int DB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic d_out
);

    logic meta_q, sd_sync_q, sd_db_q, sd_db_d;

    if (DB_CYC < 1) begin : g_bad_db_cyc
        $error("sd_debounce: DB_CYC must be at least 1");
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q    <= SD_DB_RST;
            sd_sync_q <= SD_DB_RST;
        end else begin
            meta_q    <= d_in;
            sd_sync_q <= meta_q;
        end
    end

`ifdef RATE_TICK_DEBOUNCE_EN
    localparam int CW = DB_CYC > 1 ? $clog2(DB_CYC) : 1;

    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic          db_done;

    assign db_done = db_cnt_q == CW'(DB_CYC - 1);

    // The counter only advances while the synchronized level disagrees with the
    // accepted level, so any shorter excursion is forgotten on return.
    always_comb begin
        db_cnt_d = (sd_sync_q == sd_db_q || db_done) ? '0 : db_cnt_q + 1'b1;
        sd_db_d  = (sd_sync_q != sd_db_q && db_done) ? sd_sync_q : sd_db_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            sd_db_q  <= SD_DB_RST;
        end else begin
            db_cnt_q <= db_cnt_d;
            sd_db_q  <= sd_db_d;
        end
    end
`else
    assign sd_db_d = sd_sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) sd_db_q <= SD_DB_RST;
        else        sd_db_q <= sd_db_d;
    end
`endif

    assign d_out = sd_db_q;

endmodule

// File: rtl/rate_tick_gen.sv
// rate_tick_gen: dual-rate timebase producing slow/fast square waves, tick pulses and a glitch-free selected tick
// Ports: clk, rst_n (sync, active low), sd_in (raw switch, 1 = slow),
//        outclk1/outclk12 (slow/fast square waves), tick_slow/tick_fast (one-cycle rate ticks),
//        tick_sel (tick of the applied rate), sel_slow (applied selection, 1 = slow)
// Macro RATE_TICK_DEBOUNCE_EN selects the debounced switch path inside sd_debounce.
module rate_tick_gen
    import rate_tick_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SLOW_HZ = 1,
    parameter int FAST_HZ = 12,
    parameter int DB_CYC  = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sd_in,
    output logic outclk1,
    output logic outclk12,
    output logic tick_slow,
    output logic tick_fast,
    output logic tick_sel,
    output logic sel_slow
);

    localparam int SLOW_DIV = div_of(CLK_HZ, SLOW_HZ);
    localparam int FAST_DIV = div_of(CLK_HZ, FAST_HZ);
    localparam int SW       = $clog2(SLOW_DIV);
    localparam int FW       = $clog2(FAST_DIV);

    if (FAST_DIV < 2 || FAST_DIV >= SLOW_DIV) begin : g_bad_div
        $error("rate_tick_gen: dividers must satisfy 2 <= FAST_DIV < SLOW_DIV");
    end

    logic          sd_db;
    logic [SW-1:0] slow_cnt_q, slow_cnt_d;
    logic [FW-1:0] fast_cnt_q, fast_cnt_d;
    logic          tick_slow_q, tick_fast_q, tick_sel_q, tick_sel_d;
    logic          outclk1_q, outclk12_q, sel_slow_q, sel_slow_d;
    rate_state_t   state_q, state_d;

    sd_debounce #(.DB_CYC(DB_CYC)) u_db (
        .clk  (clk),
        .rst_n(rst_n),
        .d_in (sd_in),
        .d_out(sd_db)
    );

    always_comb begin
        slow_cnt_d = slow_cnt_q == SW'(SLOW_DIV - 1) ? '0 : slow_cnt_q + 1'b1;
        fast_cnt_d = fast_cnt_q == FW'(FAST_DIV - 1) ? '0 : fast_cnt_q + 1'b1;
    end

    // ARM states hold tick_sel low until the target rate completes a full
    // period; the counters free-run, so its next tick always ends a whole period.
    always_comb begin
        state_d    = state_q;
        tick_sel_d = 1'b0;
        case (state_q)
            RUN_SLOW: if (!sd_db) state_d = ARM_FAST; else tick_sel_d = tick_slow_q;
            ARM_FAST: if (sd_db) state_d = RUN_SLOW;
                      else if (tick_fast_q) begin
                          tick_sel_d = 1'b1;
                          state_d    = RUN_FAST;
                      end
            RUN_FAST: if (sd_db) state_d = ARM_SLOW; else tick_sel_d = tick_fast_q;
            ARM_SLOW: if (!sd_db) state_d = RUN_FAST;
                      else if (tick_slow_q) begin
                          tick_sel_d = 1'b1;
                          state_d    = RUN_SLOW;
                      end
            default:  state_d = RUN_SLOW;
        endcase
        sel_slow_d = state_d == RUN_SLOW || state_d == ARM_FAST;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slow_cnt_q  <= '0;
            fast_cnt_q  <= '0;
            tick_slow_q <= 1'b0;
            tick_fast_q <= 1'b0;
            tick_sel_q  <= 1'b0;
            outclk1_q   <= 1'b1;
            outclk12_q  <= 1'b1;
            sel_slow_q  <= SEL_SLOW_RST;
            state_q     <= RUN_SLOW;
        end else begin
            slow_cnt_q  <= slow_cnt_d;
            fast_cnt_q  <= fast_cnt_d;
            tick_slow_q <= slow_cnt_q == SW'(SLOW_DIV - 1);
            tick_fast_q <= fast_cnt_q == FW'(FAST_DIV - 1);
            tick_sel_q  <= tick_sel_d;
            // Decoding the next count keeps the square waves aligned with the counter value.
            outclk1_q   <= slow_cnt_d < SW'(SLOW_DIV / 2);
            outclk12_q  <= fast_cnt_d < FW'(FAST_DIV / 2);
            sel_slow_q  <= sel_slow_d;
            state_q     <= state_d;
        end
    end

    assign outclk1   = outclk1_q;
    assign outclk12  = outclk12_q;
    assign tick_slow = tick_slow_q;
    assign tick_fast = tick_fast_q;
    assign tick_sel  = tick_sel_q;
    assign sel_slow  = sel_slow_q;

endmodule

// File: tb/tb_rate_tick_gen.sv
// tb_rate_tick_gen: directed self-checking bench for rate_tick_gen (CLK_HZ=120, SLOW_DIV=120, FAST_DIV=10, DB_CYC=4)
module tb_rate_tick_gen;

`ifdef RATE_TICK_DEBOUNCE_EN
    localparam int LAT   = 6;
    localparam bit DB_EN = 1'b1;
`else
    localparam int LAT   = 3;
    localparam bit DB_EN = 1'b0;
`endif

    logic clk, rst_n, sd_in;
    logic outclk1, outclk12, tick_slow, tick_fast, tick_sel, sel_slow;
    int   n_chk, n_fail, edge_n;
    logic [6:0] got, exp;

    rate_tick_gen #(.CLK_HZ(120), .SLOW_HZ(1), .FAST_HZ(12), .DB_CYC(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sd_in    (sd_in),
        .outclk1  (outclk1),
        .outclk12 (outclk12),
        .tick_slow(tick_slow),
        .tick_fast(tick_fast),
        .tick_sel (tick_sel),
        .sel_slow (sel_slow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    // Free-running part: {tick_fast, tick_slow, outclk12, outclk1} after edge e since reset release.
    function automatic logic [3:0] free_run(input int e);
        return {e % 10 == 0 && e > 0, e % 120 == 0 && e > 0, (e % 10) < 5, (e % 120) < 60};
    endfunction

    function automatic logic [6:0] observed();
        return {tick_fast, tick_slow, outclk12, outclk1, tick_sel, sel_slow, dut.sd_db};
    endfunction

    task automatic test_reset(input string name);
        rst_n = 1'b0;
        sd_in = 1'b1;
        step(2);
        got = observed();
        exp = 7'b0011011;
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: {tf,ts,o12,o1,sel,sels,db} got %b want %b", name, got, exp);
        end
    endtask

    task automatic test_cadence();
        rst_n  = 1'b1;
        edge_n = 0;
        while (edge_n < 121) begin
            step(1);
            got = observed();
            exp = {free_run(edge_n), edge_n == 121, 1'b1, 1'b1};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL cadence edge %0d: got %b want %b", edge_n, got, exp);
            end
        end
    endtask

    task automatic test_glitch();
        while (edge_n < 241) begin
            sd_in = !(edge_n >= 121 && edge_n < (DB_EN ? 124 : 122));
            step(1);
            got = observed();
            exp = {free_run(edge_n), edge_n == 241, 1'b1, !(!DB_EN && edge_n == 124)};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL glitch edge %0d: got %b want %b", edge_n, got, exp);
            end
        end
    endtask

    task automatic test_arm_cancel();
        while (edge_n < 361) begin
            sd_in = !(edge_n >= 248 && edge_n < 252);
            step(1);
            got = observed();
            exp = {free_run(edge_n), edge_n == 361, 1'b1, !(edge_n >= 248 + LAT && edge_n < 252 + LAT)};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL arm_cancel edge %0d: got %b want %b", edge_n, got, exp);
            end
        end
    endtask

    task automatic test_switch_fast();
        while (edge_n < 395) begin
            sd_in = edge_n < 370 - LAT;
            step(1);
            got = observed();
            exp = {free_run(edge_n), edge_n == 381 || edge_n == 391, edge_n < 381, edge_n < 370};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL switch_fast edge %0d: got %b want %b", edge_n, got, exp);
            end
        end
    endtask

    task automatic test_arm_slow_reset();
        while (edge_n < 415) begin
            sd_in = edge_n >= 400;
            step(1);
            got = observed();
            exp = {free_run(edge_n), edge_n == 401, 1'b0, edge_n >= 400 + LAT};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL arm_slow edge %0d: got %b want %b", edge_n, got, exp);
            end
        end
        rst_n = 1'b0;
        step(1);
        got = observed();
        exp = 7'b0011011;
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL mid_reset: got %b want %b", got, exp);
        end
        rst_n  = 1'b1;
        edge_n = 0;
        while (edge_n < 25) begin
            step(1);
            got = observed();
            exp = {free_run(edge_n), 1'b0, 1'b1, 1'b1};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL restart edge %0d: got %b want %b", edge_n, got, exp);
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        edge_n = 0;
        test_reset("reset");
        test_cadence();
        test_glitch();
        test_arm_cancel();
        test_switch_fast();
        test_arm_slow_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rate_tick_gen.md
# rate_tick_gen

Dual-rate timebase for the shift-register LED path. It divides the system clock into a slow rate (nominal 1 Hz) and a fast rate (nominal 12 Hz), and produces both as square waves and as single-cycle tick pulses. It synchronizes and debounces the raw speed switch `sd_in` and emits one selected tick stream, `tick_sel`, that changes rate only on a clean tick boundary of the new rate. Downstream logic shifts on `tick_sel` as a clock enable and never uses a muxed clock.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `SLOW_HZ`, 1, slow rate; `SLOW_DIV = CLK_HZ/SLOW_HZ`, which must be ≥ 2.
- `FAST_HZ`, 12, fast rate; `FAST_DIV = CLK_HZ/FAST_HZ`, which must be ≥ 2 and < `SLOW_DIV`.
- `DB_CYC`, 1_000_000, number of stable cycles required to accept a switch change; must be ≥ 1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `sd_in`  in  1  raw asynchronous switch; 1 selects slow, 0 selects fast.
- `outclk1`  out  1  slow square wave, high while `slow_cnt < SLOW_DIV/2`.
- `outclk12`  out  1  fast square wave, high while `fast_cnt < FAST_DIV/2`.
- `tick_slow`  out  1  one-cycle pulse per slow period.
- `tick_fast`  out  1  one-cycle pulse per fast period.
- `tick_sel`  out  1  one-cycle pulse from the currently applied rate.
- `sel_slow`  out  1  applied selection; 1 = slow.

## Operation
- **Counters.**
  - `slow_cnt` is `$clog2(SLOW_DIV)` bits wide and counts 0..SLOW_DIV-1, wrapping to 0. `fast_cnt` behaves the same with `FAST_DIV`.
  - The counters free-run and are never reset by a selection change.
  - `tick_x` is registered and equals `(x_cnt == DIV-1)` sampled on the previous edge.
  - `outclk*` are registered decodes of the counter value.
- **Switch path.**
  - 2-FF synchronizer produces `sd_sync`, which feeds the debouncer to produce `sd_db`.
  - `db_cnt` clears whenever `sd_sync == sd_db`. Otherwise it increments.
  - When `db_cnt == DB_CYC-1` with a mismatch, `sd_db <= sd_sync` and `db_cnt <= 0`.
- **FSM states:** RUN_SLOW, ARM_FAST, RUN_FAST, ARM_SLOW.
  - RUN_SLOW: if `sd_db` = 0, go to ARM_FAST. Else `tick_sel <= tick_slow`.
  - ARM_FAST: `tick_sel <= 0`. If `sd_db` = 1, go back to RUN_SLOW. Else if `tick_fast`, set `tick_sel <= 1` and go to RUN_FAST.
  - RUN_FAST and ARM_SLOW mirror these with the roles swapped.
  - `sel_slow` is 1 in RUN_SLOW and ARM_FAST, and 0 in RUN_FAST and ARM_SLOW.
- **Boundary rules.**
  - If the new-rate tick and the `sd_db` change occur in the same cycle, the FSM enters ARM and that tick is not passed.
  - If both rate ticks coincide in an ARM state, the target-rate tick wins.
  - No `tick_sel` pulse is ever emitted from a partial period of the new rate.
- **Reset values:**
  - All counters are 0.
  - `sd_sync` = 1 and `sd_db` = 1.
  - State is RUN_SLOW.
  - All tick outputs are 0.
  - `outclk1` = 1, `outclk12` = 1, `sel_slow` = 1.
- **Reset asserted mid-operation:** every register returns to its reset value on that edge. No pending ARM transition survives the reset.

## Timing
- `tick_fast` first goes high after the FAST_DIV-th rising edge following reset release, then pulses every FAST_DIV cycles. `tick_slow` behaves likewise with SLOW_DIV.
- `tick_sel` lags the source tick by 1 cycle.
- Switch latency: `sd_in` change → `sd_sync` after 2 edges → `sd_db` after DB_CYC more edges → ARM state on the next edge.
- Switchover gap: between 1 and DIV_new+1 cycles of no `tick_sel` after entering ARM.
- Glitches shorter than DB_CYC cycles on `sd_sync` never change `sd_db`.

## Configuration
- `RATE_TICK_DEBOUNCE_EN` defined: debouncer present as described above.
- `RATE_TICK_DEBOUNCE_EN` undefined: `sd_db` is a register that follows `sd_sync` with 1 cycle of delay. `DB_CYC` is ignored and no `db_cnt` exists.

## Structure
- Package `rate_tick_pkg` contains:
  - the FSM state enum `rate_state_t` (2 bits);
  - a `div_of(clk_hz, hz)` function;
  - the reset constants for `sd_db` and `sel_slow`.
- Sub-module `sd_debounce` holds the synchronizer and the debouncer, including the macro switch. Ports: `clk`, `rst_n`, `d_in`, `d_out`.
- Top-level `rate_tick_gen` holds the counters, tick decode and FSM.

## Test plan
All scenarios use `CLK_HZ`=120, `SLOW_HZ`=1, `FAST_HZ`=12, `DB_CYC`=4, so `SLOW_DIV`=120 and `FAST_DIV`=10.
- Reset release with `sd_in`=1 → `tick_fast` at edges 10, 20, 30…; `tick_slow` at edge 120; `tick_sel` at edge 121; `sel_slow`=1 throughout.
- `sd_in` 1→0 held → `sd_db` falls 6 edges later; ARM_FAST; next `tick_fast` gives `tick_sel` 1 cycle later; `sel_slow`=0; no other `tick_sel` pulses in between.
- 3-cycle low glitch on `sd_in` while slow → `sd_db` stays 1, state stays RUN_SLOW, `tick_sel` cadence stays 120.
- `sd_db` toggles 0 then back to 1 within 5 cycles while in ARM_FAST → back to RUN_SLOW; next `tick_sel` lands exactly on the slow cadence.
- `rst_n` low for 1 cycle while in ARM_SLOW → all outputs at reset values on the next cycle; cadence restarts from count 0.
- Macro undefined: `sd_in` 1→0 → `sd_db` falls 3 edges later; a 1-cycle glitch propagates to `sd_db`.
